// File: rtl/dataflow_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dataflow_sequencer                                               |
// | Brief  : Multi-tile LOAD/COMPUTE/STORE sequencer with config/status regs. |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
module dataflow_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TILE_W     = 16,
  parameter int TMO_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_process,
  output logic                  process_done,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic                  cfg_write,
  input  logic                  cfg_read,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  cfg_ready,
  output logic                  load_data,
  output logic                  compute_enable,
  output logic                  store_result,
  input  logic                  data_ready,
  input  logic                  compute_done,
  input  logic                  store_complete,
  output logic [TILE_W-1:0]     tile_index,
  output logic                  busy,
  output logic                  irq
);

  localparam int              c_TC_W     = (TILE_W < 16) ? TILE_W : 16;
  localparam logic [TILE_W-1:0] c_TILE_ONE = {{(TILE_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  c_TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_STORE   = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t              r_state, w_next;
  logic [TILE_W-1:0]   r_tile_count, r_tile_total, r_tile_index, r_tiles_done;
  logic [TMO_W-1:0]    r_timeout, r_tmo, r_phase_cnt;
  logic                r_irq_en, r_done_sticky, r_err_sticky, r_aborted;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                w_wr_ctrl, w_wr_tc, w_wr_tmo, w_wr_stat;
  logic                w_start, w_abort_req, w_abort, w_busy;
  logic                w_tmo_hit, w_last_tile, w_store_ack;
  logic                w_unused;

  assign w_wr_ctrl   = cfg_write && (cfg_addr[3:2] == 2'd0);
  assign w_wr_tc     = cfg_write && (cfg_addr[3:2] == 2'd1);
  assign w_wr_tmo    = cfg_write && (cfg_addr[3:2] == 2'd2);
  assign w_wr_stat   = cfg_write && (cfg_addr[3:2] == 2'd3);
  assign w_busy      = (r_state != S_IDLE);
  // Abort dominates a start written in the same cycle, even when idle.
  assign w_abort_req = w_wr_ctrl && cfg_wdata[1];
  assign w_start     = (start_process || (w_wr_ctrl && cfg_wdata[0])) && !w_abort_req;
  assign w_abort     = w_abort_req && w_busy;
  assign w_tmo_hit   = (r_tmo != '0) && (r_phase_cnt == (r_tmo - c_TMO_ONE));
  assign w_last_tile = (r_tile_index == (r_tile_total - c_TILE_ONE));
  assign w_unused    = ^{cfg_addr[ADDR_WIDTH-1:4], cfg_addr[1:0], cfg_wdata, r_tiles_done};

  always_comb begin
    w_next      = r_state;
    w_store_ack = 1'b0;
    case (r_state)
      S_IDLE:    if (w_start) w_next = (r_tile_count != '0) ? S_LOAD : S_DONE;
      S_LOAD:    if (data_ready) w_next = S_COMPUTE;
                 else if (w_tmo_hit) w_next = S_ERROR;
      S_COMPUTE: if (compute_done) w_next = S_STORE;
                 else if (w_tmo_hit) w_next = S_ERROR;
      S_STORE: begin
        if (store_complete) begin
          w_store_ack = 1'b1;
          w_next      = w_last_tile ? S_DONE : S_LOAD;
        end else if (w_tmo_hit) begin
          w_next = S_ERROR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next      = S_IDLE;
      w_store_ack = 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (cfg_addr[3:2])
      2'd0: w_rd_mux[2] = r_irq_en;
      2'd1: w_rd_mux[TILE_W-1:0] = r_tile_count;
      2'd2: w_rd_mux[TMO_W-1:0] = r_timeout;
      default: begin
        w_rd_mux[0]           = w_busy;
        w_rd_mux[1]           = r_done_sticky;
        w_rd_mux[2]           = r_err_sticky;
        w_rd_mux[3]           = r_aborted;
        w_rd_mux[16 +: c_TC_W] = r_tiles_done[c_TC_W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tile_count  <= '0;
      r_tile_total  <= '0;
      r_tile_index  <= '0;
      r_tiles_done  <= '0;
      r_timeout     <= '0;
      r_tmo         <= '0;
      r_phase_cnt   <= '0;
      r_irq_en      <= 1'b0;
      r_done_sticky <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_aborted     <= 1'b0;
      cfg_ready     <= 1'b0;
      cfg_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_phase_cnt <= (w_next != r_state) ? '0 : r_phase_cnt + c_TMO_ONE;
      if (r_state == S_IDLE && w_start) begin
        r_tile_total <= r_tile_count;
        r_tmo        <= r_timeout;
        r_tile_index <= '0;
        r_tiles_done <= '0;
      end
      if (w_store_ack) begin
        r_tiles_done <= r_tiles_done + c_TILE_ONE;
        if (!w_last_tile) r_tile_index <= r_tile_index + c_TILE_ONE;
      end
      if (w_wr_ctrl) r_irq_en <= cfg_wdata[2];
      if (w_wr_tc && !w_busy) r_tile_count <= cfg_wdata[TILE_W-1:0];
      if (w_wr_tmo && !w_busy) r_timeout <= cfg_wdata[TMO_W-1:0];
      if (w_wr_stat) begin
        if (cfg_wdata[1]) r_done_sticky <= 1'b0;
        if (cfg_wdata[2]) r_err_sticky  <= 1'b0;
        if (cfg_wdata[3]) r_aborted     <= 1'b0;
      end
      // Hardware set events take priority over a simultaneous W1C.
      if (r_state == S_DONE) r_done_sticky <= 1'b1;
      if (r_state == S_ERROR || w_abort) r_err_sticky <= 1'b1;
      if (w_abort) r_aborted <= 1'b1;
      cfg_ready <= cfg_read || cfg_write;
      cfg_rdata <= (cfg_read && !cfg_write) ? w_rd_mux : '0;
    end
  end

  assign load_data      = (r_state == S_LOAD);
  assign compute_enable = (r_state == S_COMPUTE);
  assign store_result   = (r_state == S_STORE);
  assign process_done   = (r_state == S_DONE);
  assign busy           = w_busy;
  assign tile_index     = r_tile_index;
  assign irq            = (r_done_sticky || r_err_sticky) && r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_dataflow_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_dataflow_sequencer                                            |
// | Brief  : Directed self-checking bench for dataflow_sequencer.             |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
module tb_dataflow_sequencer;

  logic        clk = 1'b0;
  logic        reset, start_process, process_done;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
  logic        cfg_write, cfg_read, cfg_ready;
  logic        load_data, compute_enable, store_result;
  logic        data_ready, compute_done, store_complete;
  logic [15:0] tile_index;
  logic        busy, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int pd_cnt   = 0;
  int ld_cnt   = 0;
  logic [31:0] rd;

  dataflow_sequencer dut (
    .clk(clk), .reset(reset), .start_process(start_process), .process_done(process_done),
    .cfg_addr(cfg_addr), .cfg_write(cfg_write), .cfg_read(cfg_read), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_ready(cfg_ready), .load_data(load_data),
    .compute_enable(compute_enable), .store_result(store_result), .data_ready(data_ready),
    .compute_done(compute_done), .store_complete(store_complete), .tile_index(tile_index),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (process_done) pd_cnt <= pd_cnt + 1;
    if (load_data)    ld_cnt <= ld_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_write = 1'b1;
    tick();
    cfg_write = 1'b0;
    chk("wr_ready", {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
    cfg_addr = a;
    cfg_read = 1'b1;
    tick();
    cfg_read = 1'b0;
    chk("rd_ready", {31'd0, cfg_ready}, 32'd1);
    d = cfg_rdata;
  endtask

  task automatic pulse_start();
    start_process = 1'b1;
    tick();
    start_process = 1'b0;
  endtask

  function automatic logic phase_sig(input int ph);
    case (ph)
      0:       return load_data;
      1:       return compute_enable;
      default: return store_result;
    endcase
  endfunction

  // Wait for the phase output, then answer it two cycles later.
  task automatic do_phase(input int ph, input int exp_tile);
    logic seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (phase_sig(ph)) seen = 1'b1;
      else tick();
    end
    chk($sformatf("phase%0d_seen", ph), {31'd0, seen}, 32'd1);
    chk($sformatf("phase%0d_tile", ph), {16'd0, tile_index}, exp_tile);
    tick();
    tick();
    case (ph)
      0:       data_ready = 1'b1;
      1:       compute_done = 1'b1;
      default: store_complete = 1'b1;
    endcase
    tick();
    data_ready = 1'b0;
    compute_done = 1'b0;
    store_complete = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      if (!busy) idle = 1'b1;
      else tick();
    end
    chk(tag, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start_process = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_write = 1'b0; cfg_read = 1'b0;
    data_ready = 1'b0; compute_done = 1'b0; store_complete = 1'b0;
    tick(); tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {26'd0, process_done, load_data, compute_enable, store_result, cfg_ready, irq}, 32'd0);
    chk("rst_tile", {16'd0, tile_index}, 32'd0);
    reset = 1'b0;
    tick();

    // Register access
    cfg_wr(32'h8, 32'h40);
    cfg_rd(32'h8, rd);
    chk("tmo_read", rd, 32'h40);
    tick();
    chk("ready_drop", {31'd0, cfg_ready}, 32'd0);
    cfg_wr(32'h0, 32'h7);
    chk("start_abort_idle", {31'd0, busy}, 32'd0);
    cfg_rd(32'h0, rd);
    chk("ctrl_read", rd, 32'h4);
    cfg_wr(32'h0, 32'h0);
    cfg_addr = 32'h8; cfg_wdata = 32'h41; cfg_write = 1'b1; cfg_read = 1'b1;
    tick();
    cfg_write = 1'b0; cfg_read = 1'b0;
    chk("rw_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rw_rdata", cfg_rdata, 32'h0);
    cfg_rd(32'h8, rd);
    chk("rw_wrote", rd, 32'h41);
    cfg_wr(32'h8, 32'h0);

    // Three tiles
    cfg_wr(32'h4, 32'd3);
    pd_cnt = 0;
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      do_phase(0, t);
      do_phase(1, t);
      do_phase(2, t);
    end
    wait_idle("three_idle");
    tick();
    chk("three_pd", pd_cnt, 32'd1);
    cfg_rd(32'hC, rd);
    chk("three_status", rd, 32'h0003_0002);
    chk("three_irq", {31'd0, irq}, 32'd0);
    cfg_wr(32'hC, 32'hE);

    // Zero tile count
    cfg_wr(32'h4, 32'd0);
    pd_cnt = 0; ld_cnt = 0;
    start_process = 1'b1;
    tick();
    start_process = 1'b0;
    chk("zero_pd_hi", {31'd0, process_done}, 32'd1);
    tick();
    chk("zero_pd_lo", {30'd0, process_done, busy}, 32'd0);
    chk("zero_pd_cnt", pd_cnt, 32'd1);
    chk("zero_no_load", ld_cnt, 32'd0);
    cfg_rd(32'hC, rd);
    chk("zero_status", rd, 32'h0000_0002);
    cfg_wr(32'hC, 32'hE);

    // Timeout in LOAD
    cfg_wr(32'h8, 32'd5);
    cfg_wr(32'h4, 32'd1);
    cfg_wr(32'h0, 32'h4);
    pd_cnt = 0; ld_cnt = 0;
    pulse_start();
    wait_idle("tmo_idle");
    tick();
    chk("tmo_load_cycles", ld_cnt, 32'd5);
    chk("tmo_no_pd", pd_cnt, 32'd0);
    cfg_rd(32'hC, rd);
    chk("tmo_status", rd, 32'h0000_0004);
    chk("tmo_irq", {31'd0, irq}, 32'd1);
    cfg_wr(32'hC, 32'h4);
    chk("tmo_irq_clr", {31'd0, irq}, 32'd0);
    cfg_wr(32'h8, 32'd0);
    cfg_wr(32'h0, 32'h0);

    // Abort during COMPUTE of tile 1
    cfg_wr(32'h4, 32'd4);
    pd_cnt = 0;
    pulse_start();
    do_phase(0, 0);
    do_phase(1, 0);
    do_phase(2, 0);
    do_phase(0, 1);
    chk("abort_in_compute", {31'd0, compute_enable}, 32'd1);
    cfg_wr(32'h0, 32'h2);
    chk("abort_ce_low", {30'd0, compute_enable, busy}, 32'd0);
    cfg_rd(32'hC, rd);
    chk("abort_status", rd, 32'h0001_000C);
    chk("abort_tile_hold", {16'd0, tile_index}, 32'd1);
    tick();
    chk("abort_no_pd", pd_cnt, 32'd0);
    cfg_wr(32'hC, 32'hE);

    // Robustness: early handshake, start and TILE_COUNT write while busy
    cfg_wr(32'h4, 32'd1);
    pd_cnt = 0;
    pulse_start();
    chk("rob_load", {31'd0, load_data}, 32'd1);
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("rob_early_cd", {31'd0, load_data}, 32'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("rob_ce", {31'd0, compute_enable}, 32'd1);
    tick(); tick();
    pulse_start();
    cfg_wr(32'h4, 32'd9);
    chk("rob_ce_stays", {31'd0, compute_enable}, 32'd1);
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("rob_store", {31'd0, store_result}, 32'd1);
    store_complete = 1'b1;
    tick();
    store_complete = 1'b0;
    wait_idle("rob_idle");
    tick(); tick();
    chk("rob_pd", pd_cnt, 32'd1);
    cfg_rd(32'h4, rd);
    chk("rob_tc_kept", rd, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
